// File: rtl/poc_host_ctrl.sv
// Host-side controller that drains a small byte FIFO into a POC peripheral:
// it reads POC status, waits for ready (polled or by interrupt), writes the data byte, then the status.
module poc_host_ctrl #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int DELAY_CYC = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_irq,
  input  logic [DW-1:0]              i_dout,
  input  logic [DW-1:0]              i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [DW-1:0]              o_din,
  output logic                       o_addr,
  output logic                       o_rw,
  output logic                       o_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic [15:0]                o_sent_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_STATUS = 3'd1,
    CHECK     = 3'd2,
    WR_DATA   = 3'd3,
    DELAY     = 3'd4,
    WR_STATUS = 3'd5
  } state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] status_q;
  logic [3:0]    dly_cnt;
  logic          full;
  logic          push;
  logic          pop;

  // Status written back to the POC acknowledges the byte by clearing the ready bit.
  function automatic logic [DW-1:0] clr_ready(input logic [DW-1:0] s);
    logic [DW-1:0] r;
    r    = s;
    r[7] = 1'b0;
    return r;
  endfunction

  assign full    = (o_level == LW'(DEPTH));
  assign o_ready = !full;
  assign push    = i_valid && !full;
  assign pop     = (state == WR_DATA);

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   o_level <= o_level + LW'(1);
        2'b01:   o_level <= o_level - LW'(1);
        default: o_level <= o_level;
      endcase
    end
  end

  // Outputs are loaded together with the state they belong to, so they never depend on i_dout directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      status_q   <= '0;
      dly_cnt    <= 4'd0;
      o_sent_cnt <= 16'd0;
      o_din      <= '0;
      o_addr     <= 1'b0;
      o_rw       <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (o_level != '0) begin
            state  <= RD_STATUS;
            o_busy <= 1'b1;
          end
        end
        RD_STATUS: begin
          status_q <= i_dout;
          state    <= CHECK;
        end
        CHECK: begin
          // Bit 0 selects interrupt mode; otherwise bit 7 is the polled ready flag.
          if (status_q[0] ? !i_irq : status_q[7]) begin
            state  <= WR_DATA;
            o_addr <= 1'b1;
            o_rw   <= 1'b1;
            o_din  <= mem[rd_ptr];
          end else if (!status_q[0]) begin
            state <= RD_STATUS;
          end
        end
        WR_DATA: begin
          o_sent_cnt <= o_sent_cnt + 16'd1;
          dly_cnt    <= 4'd0;
          state      <= DELAY;
          o_rw       <= 1'b0;
          o_din      <= '0;
        end
        DELAY: begin
          if (dly_cnt == 4'(DELAY_CYC - 1)) begin
            dly_cnt <= 4'd0;
            state   <= WR_STATUS;
            o_addr  <= 1'b0;
            o_rw    <= 1'b1;
            o_din   <= clr_ready(status_q);
          end else begin
            dly_cnt <= dly_cnt + 4'd1;
          end
        end
        WR_STATUS: begin
          state  <= IDLE;
          o_rw   <= 1'b0;
          o_din  <= '0;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_addr <= 1'b0;
          o_rw   <= 1'b0;
          o_din  <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poc_host_ctrl.sv
// Scoreboard bench for poc_host_ctrl: accepted bytes are queued on push and
// compared against each POC data write; status writes and idle o_din are checked too.
module tb_poc_host_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq;
  logic [7:0]  dout;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [7:0]  din;
  logic        addr;
  logic        rw;
  logic        busy;
  logic [2:0]  level;
  logic [15:0] sent_cnt;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  sb[$];
  logic [7:0]  exp_status = 8'h00;
  logic        found;
  logic        any_wr;

  poc_host_ctrl #(.DW(8), .DEPTH(4), .DELAY_CYC(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_dout(dout), .i_data(data),
    .i_valid(valid), .o_ready(ready), .o_din(din), .o_addr(addr), .o_rw(rw),
    .o_busy(busy), .o_level(level), .o_sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] b, input logic acc);
    chk("ready_before_push", 32'(ready), 32'(acc));
    valid = 1'b1;
    data  = b;
    if (acc) sb.push_back(b);
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_wr_data(input int max);
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      if (addr && rw) found = 1'b1;
      else tick();
    end
    chk("wr_data_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input int max);
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      if (!busy && level == 3'd0) found = 1'b1;
      else tick();
    end
    chk("idle_reached", 32'(found), 32'd1);
  endtask

  // Bus monitor: every POC write is checked against the scoreboard or expected status.
  always @(negedge clk) begin
    if (!rst) begin
      if (rw && addr) begin
        chk("wr_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("wr_data", 32'(din), 32'(sb.pop_front()));
      end else if (rw && !addr) begin
        chk("wr_status", 32'(din), 32'(exp_status));
      end else begin
        chk("din_zero", 32'(din), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; irq = 1'b1; dout = 8'h00; data = 8'h00; valid = 1'b0;
    tick(); tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr_rw", 32'({addr, rw}), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_sent", 32'(sent_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Polling, POC ready: exact latency and bus sequence.
    dout = 8'h80; exp_status = 8'h00;
    drive(8'hA5, 1'b1);
    chk("lat_level", 32'(level), 32'd1);
    chk("lat_idle", 32'(busy), 32'd0);
    tick(); chk("lat_rd", 32'({busy, addr, rw}), 32'b100);
    tick(); chk("lat_check", 32'({busy, addr, rw}), 32'b100);
    tick(); chk("lat_wr_data", 32'({addr, rw}), 32'b11);
    tick(); chk("delay1", 32'({addr, rw}), 32'b10);
    chk("sent_1", 32'(sent_cnt), 32'd1);
    tick(); chk("delay2", 32'({addr, rw}), 32'b10);
    tick(); chk("wr_status_bus", 32'({addr, rw}), 32'b01);
    tick(); chk("back_idle", 32'(busy), 32'd0);

    // Polling, not ready: no write while bit 7 stays low.
    dout = 8'h00;
    drive(8'h3C, 1'b1);
    any_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rw) any_wr = 1'b1;
    end
    chk("poll_no_write", 32'(any_wr), 32'd0);
    chk("poll_busy", 32'(busy), 32'd1);
    dout = 8'h80;
    wait_wr_data(10);
    wait_idle(20);
    chk("sent_2", 32'(sent_cnt), 32'd2);

    // Interrupt mode: hold in CHECK until irq goes low; status write keeps bit 0.
    dout = 8'h01; irq = 1'b1; exp_status = 8'h01;
    drive(8'h5A, 1'b1);
    any_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rw) any_wr = 1'b1;
    end
    chk("irq_no_write", 32'(any_wr), 32'd0);
    chk("irq_busy", 32'(busy), 32'd1);
    irq = 1'b0;
    wait_wr_data(5);
    wait_idle(20);
    irq = 1'b1;
    chk("sent_3", 32'(sent_cnt), 32'd3);

    // Full FIFO: fifth byte dropped, order 1..4 on delivery.
    dout = 8'h00; exp_status = 8'h00;
    for (int i = 0; i < 5; i++) drive(8'(8'h11 * (i + 1)), i < 4);
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready", 32'(ready), 32'd0);
    dout = 8'h80;
    wait_idle(100);
    chk("sent_7", 32'(sent_cnt), 32'd7);

    // Simultaneous push and pop in the WR_DATA cycle.
    dout = 8'h00;
    drive(8'h66, 1'b1);
    drive(8'h77, 1'b1);
    dout = 8'h80;
    wait_wr_data(10);
    chk("pp_level_before", 32'(level), 32'd2);
    drive(8'h88, 1'b1);
    chk("pp_level_after", 32'(level), 32'd2);
    wait_idle(100);
    chk("sent_10", 32'(sent_cnt), 32'd10);

    // Reset in DELAY with three bytes still queued.
    dout = 8'h00;
    for (int i = 0; i < 4; i++) drive(8'(8'hC0 + i), 1'b1);
    dout = 8'h80;
    wait_wr_data(10);
    tick();
    chk("mid_delay_bus", 32'({busy, addr, rw}), 32'b110);
    chk("mid_level", 32'(level), 32'd3);
    rst = 1'b1;
    sb.delete();
    tick();
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_rw", 32'(rw), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sent", 32'(sent_cnt), 32'd0);
    rst = 1'b0;
    any_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rw || busy) any_wr = 1'b1;
    end
    chk("post_rst_quiet", 32'(any_wr), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
